// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue/writeback stage: widths, opcodes,
// FSM states and instruction field positions.
package alu_issue_ctrl_pkg;

    localparam int DATA_W = 16;
    localparam int NREG   = 8;
    localparam int REG_AW = 3;
    localparam int OP_W   = 4;

    localparam logic [OP_W-1:0] OP_NOP = 4'b0000;
    localparam logic [OP_W-1:0] OP_LDI = 4'b0001;
    localparam logic [OP_W-1:0] OP_ADD = 4'b0010;
    localparam logic [OP_W-1:0] OP_SUB = 4'b0011;
    localparam logic [OP_W-1:0] OP_AND = 4'b0100;
    localparam logic [OP_W-1:0] OP_OR  = 4'b0101;
    localparam logic [OP_W-1:0] OP_XOR = 4'b0110;
    localparam logic [OP_W-1:0] OP_SR  = 4'b1000;
    localparam logic [OP_W-1:0] OP_SRA = 4'b1001;
    localparam logic [OP_W-1:0] OP_SL  = 4'b1010;

    // Instruction field positions
    localparam int F_OP_HI  = 15;
    localparam int F_OP_LO  = 12;
    localparam int F_RD_HI  = 11;
    localparam int F_RD_LO  = 9;
    localparam int F_RS1_HI = 8;
    localparam int F_RS1_LO = 6;
    localparam int F_IMMSEL = 5;
    localparam int F_RS2_HI = 4;
    localparam int F_RS2_LO = 2;
    localparam int F_IMM5_HI = 4;
    localparam int F_IMM9_HI = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WB    = 2'd2
    } state_e;

    function automatic logic is_alu_op(input logic [OP_W-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SR, OP_SRA, OP_SL: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_regfile.sv
// 8x16 register file: two combinational read ports plus a debug port,
// one synchronous write port, async active-low clear, r0 hardwired to zero.
module alu_regfile
    import alu_issue_ctrl_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [REG_AW-1:0] ra1_i,
    input  logic [REG_AW-1:0] ra2_i,
    input  logic [REG_AW-1:0] dbg_addr_i,
    output logic [DATA_W-1:0] rd1_o,
    output logic [DATA_W-1:0] rd2_o,
    output logic [DATA_W-1:0] dbg_data_o,
    input  logic              we_i,
    input  logic [REG_AW-1:0] wa_i,
    input  logic [DATA_W-1:0] wd_i
);

    logic [NREG-1:0][DATA_W-1:0] mem_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mem_q <= '0;
        end else if (we_i && (wa_i != '0)) begin
            mem_q[wa_i] <= wd_i;
        end
    end

    // r0 is never written, but the read mux forces zero anyway so the
    // guarantee does not depend on the write guard alone.
    assign rd1_o      = (ra1_i      == '0) ? '0 : mem_q[ra1_i];
    assign rd2_o      = (ra2_i      == '0) ? '0 : mem_q[ra2_i];
    assign dbg_data_o = (dbg_addr_i == '0) ? '0 : mem_q[dbg_addr_i];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback sequencer in front of a combinational 16-bit ALU:
// IDLE accepts, ISSUE drives the ALU and captures its result, WB writes back.
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [DATA_W-1:0] instr_i,
    input  logic              instr_valid_i,
    output logic              instr_ready_o,
    output logic [DATA_W-1:0] alu_a_o,
    output logic [DATA_W-1:0] alu_b_o,
    output logic [OP_W-1:0]   alu_op_o,
    input  logic [DATA_W-1:0] alu_out_i,
    input  logic              alu_zero_i,
    output logic              done_o,
    output logic              illegal_o,
    output logic              zero_flag_o,
    input  logic [REG_AW-1:0] dbg_addr_i,
    output logic [DATA_W-1:0] dbg_data_o
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic              zq_q, zq_d;
    logic              zflag_q, zflag_d;

    logic [OP_W-1:0]   op;
    logic [REG_AW-1:0] rd, rs1, rs2;
    logic              imm_sel, op_alu, op_ldi, op_legal;
    logic [DATA_W-1:0] imm5_sext, imm9_sext;
    logic [DATA_W-1:0] rs1_val, rs2_val;
    logic              rf_we;

    assign op        = instr_q[F_OP_HI:F_OP_LO];
    assign rd        = instr_q[F_RD_HI:F_RD_LO];
    assign rs1       = instr_q[F_RS1_HI:F_RS1_LO];
    assign rs2       = instr_q[F_RS2_HI:F_RS2_LO];
    assign imm_sel   = instr_q[F_IMMSEL];
    assign imm5_sext = {{(DATA_W-5){instr_q[F_IMM5_HI]}}, instr_q[F_IMM5_HI:0]};
    assign imm9_sext = {{(DATA_W-9){instr_q[F_IMM9_HI]}}, instr_q[F_IMM9_HI:0]};
    assign op_alu    = is_alu_op(op);
    assign op_ldi    = (op == OP_LDI);
    assign op_legal  = op_alu || op_ldi || (op == OP_NOP);

    alu_regfile u_rf (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .ra1_i      (rs1),
        .ra2_i      (rs2),
        .dbg_addr_i (dbg_addr_i),
        .rd1_o      (rs1_val),
        .rd2_o      (rs2_val),
        .dbg_data_o (dbg_data_o),
        .we_i       (rf_we),
        .wa_i       (rd),
        .wd_i       (res_q)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            instr_q <= '0;
            res_q   <= '0;
            zq_q    <= 1'b0;
            zflag_q <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            res_q   <= res_d;
            zq_q    <= zq_d;
            zflag_q <= zflag_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        res_d     = res_q;
        zq_d      = zq_q;
        zflag_d   = zflag_q;
        alu_a_o   = '0;
        alu_b_o   = '0;
        alu_op_o  = OP_NOP;
        done_o    = 1'b0;
        illegal_o = 1'b0;
        rf_we     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (instr_valid_i) begin
                    state_d = S_ISSUE;
                    instr_d = instr_i;
                end
            end
            S_ISSUE: begin
                state_d = S_WB;
                // Only real ALU ops reach the ALU; everything else sees op 0000
                if (op_alu) begin
                    alu_a_o  = rs1_val;
                    alu_b_o  = imm_sel ? imm5_sext : rs2_val;
                    alu_op_o = op;
                end
                res_d = op_ldi ? imm9_sext : alu_out_i;
                zq_d  = alu_zero_i;
            end
            S_WB: begin
                state_d   = S_IDLE;
                done_o    = 1'b1;
                illegal_o = !op_legal;
                rf_we     = op_alu || op_ldi;
                if (op_alu) zflag_d = zq_q;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign instr_ready_o = (state_q == S_IDLE);
    assign zero_flag_o   = zflag_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: a stand-in ALU plus an
// architectural register/flag model checked on every retired instruction.
module tb_alu_issue_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic [15:0] instr_i = '0;
    logic        instr_valid_i = 1'b0;
    logic        instr_ready_o;
    logic [15:0] alu_a_o, alu_b_o;
    logic [3:0]  alu_op_o;
    logic [15:0] alu_out_i;
    logic        alu_zero_i;
    logic        done_o, illegal_o, zero_flag_o;
    logic [2:0]  dbg_addr_i = '0;
    logic [15:0] dbg_data_o;

    int errors = 0;
    int checks = 0;

    logic [15:0] mregs [8];
    logic        mzf;

    always #5 clk_i = ~clk_i;

    alu_issue_ctrl dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .instr_i(instr_i), .instr_valid_i(instr_valid_i),
        .instr_ready_o(instr_ready_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_op_o(alu_op_o),
        .alu_out_i(alu_out_i), .alu_zero_i(alu_zero_i), .done_o(done_o), .illegal_o(illegal_o),
        .zero_flag_o(zero_flag_o), .dbg_addr_i(dbg_addr_i), .dbg_data_o(dbg_data_o)
    );

    // Stand-in for the downstream combinational ALU
    always_comb begin
        alu_out_i = '0;
        case (alu_op_o)
            4'b0010: alu_out_i = alu_a_o + alu_b_o;
            4'b0011: alu_out_i = alu_a_o - alu_b_o;
            4'b0100: alu_out_i = alu_a_o & alu_b_o;
            4'b0101: alu_out_i = alu_a_o | alu_b_o;
            4'b0110: alu_out_i = alu_a_o ^ alu_b_o;
            4'b1000: alu_out_i = alu_a_o >> alu_b_o[2:0];
            4'b1001: alu_out_i = $unsigned($signed(alu_a_o) >>> alu_b_o[2:0]);
            4'b1010: alu_out_i = alu_a_o << alu_b_o[2:0];
            default: alu_out_i = '0;
        endcase
        alu_zero_i = (alu_out_i == '0);
    end

    function automatic logic [15:0] mk(input int op, input int rd, input int rs1,
                                       input int imm, input int low5);
        logic [15:0] w;
        w = {op[3:0], rd[2:0], rs1[2:0], imm[0], low5[4:0]};
        return w;
    endfunction

    function automatic logic [15:0] mk_ldi(input int rd, input int val);
        logic [15:0] w;
        w = {4'b0001, rd[2:0], val[8:0]};
        return w;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mregs[i] = '0;
        mzf = 1'b0;
    endtask

    // One full instruction: accept, ISSUE checks, WB checks, post-WB checks.
    task automatic run_instr(input logic [15:0] ins, input string tag);
        logic [3:0]  op;
        int          rd, rs1, rs2, sh, av, bv, r;
        logic [15:0] ea, eb, res, old;
        logic        isalu, legal, wr;
        op  = ins[15:12];
        rd  = int'(ins[11:9]);
        rs1 = int'(ins[8:6]);
        rs2 = int'(ins[4:2]);
        isalu = (op inside {4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9, 4'd10});
        legal = isalu || op == 4'd0 || op == 4'd1;
        wr = isalu || op == 4'd1;
        ea = (rs1 == 0) ? 16'h0 : mregs[rs1];
        if (ins[5]) eb = 16'(signed'(ins[4:0]));
        else        eb = (rs2 == 0) ? 16'h0 : mregs[rs2];
        av = int'(ea); bv = int'(eb); sh = bv % 8;
        case (op)
            4'd2:  r = av + bv;
            4'd3:  r = av - bv;
            4'd4:  r = av & bv;
            4'd5:  r = av | bv;
            4'd6:  r = av ^ bv;
            4'd8:  r = av / (2 ** sh);
            4'd9:  r = (av >= 32768 ? av - 65536 : av) >>> sh;
            4'd10: r = av * (2 ** sh);
            4'd1:  r = int'(signed'(ins[8:0]));
            default: r = 0;
        endcase
        res = 16'(r);
        if (!isalu) begin ea = '0; eb = '0; end

        @(negedge clk_i);
        checks++;
        if (instr_ready_o !== 1'b1) begin errors++;
            $display("FAIL %s ready_before_accept got=%b exp=1", tag, instr_ready_o); end
        instr_i = ins; instr_valid_i = 1'b1; dbg_addr_i = 3'(rd);
        @(negedge clk_i);
        instr_valid_i = 1'b0; instr_i = 16'($urandom);
        checks++;
        if (alu_a_o !== ea || alu_b_o !== eb || alu_op_o !== (isalu ? op : 4'd0)
            || done_o !== 1'b0 || instr_ready_o !== 1'b0) begin errors++;
            $display("FAIL %s issue got a=%h b=%h op=%h done=%b rdy=%b exp a=%h b=%h op=%h done=0 rdy=0",
                     tag, alu_a_o, alu_b_o, alu_op_o, done_o, instr_ready_o, ea, eb,
                     isalu ? op : 4'd0);
        end
        old = mregs[rd];
        @(negedge clk_i);
        checks++;
        if (done_o !== 1'b1 || illegal_o !== !legal || dbg_data_o !== old
            || alu_op_o !== 4'd0) begin errors++;
            $display("FAIL %s wb got done=%b ill=%b dbg=%h aluop=%h exp done=1 ill=%b dbg=%h aluop=0",
                     tag, done_o, illegal_o, dbg_data_o, alu_op_o, !legal, old);
        end
        if (wr && rd != 0) mregs[rd] = res;
        if (isalu) mzf = (res == 16'h0);
        @(negedge clk_i);
        checks++;
        if (done_o !== 1'b0 || illegal_o !== 1'b0 || instr_ready_o !== 1'b1
            || dbg_data_o !== mregs[rd] || zero_flag_o !== mzf) begin errors++;
            $display("FAIL %s post got done=%b ill=%b rdy=%b dbg=%h zf=%b exp done=0 ill=0 rdy=1 dbg=%h zf=%b",
                     tag, done_o, illegal_o, instr_ready_o, dbg_data_o, zero_flag_o, mregs[rd], mzf);
        end
    endtask

    task automatic check_all_regs(input string tag);
        for (int i = 0; i < 8; i++) begin
            dbg_addr_i = 3'(i);
            #1;
            checks++;
            if (dbg_data_o !== mregs[i]) begin errors++;
                $display("FAIL %s r%0d got=%h exp=%h", tag, i, dbg_data_o, mregs[i]); end
        end
    endtask

    task automatic test_reset();
        model_reset();
        rst_n_i = 1'b0;
        repeat (2) @(negedge clk_i);
        checks++;
        if (instr_ready_o !== 1'b1 || done_o !== 1'b0 || illegal_o !== 1'b0 || zero_flag_o !== 1'b0
            || alu_a_o !== 16'h0 || alu_b_o !== 16'h0 || alu_op_o !== 4'h0) begin errors++;
            $display("FAIL reset_outputs got rdy=%b done=%b ill=%b zf=%b a=%h b=%h op=%h exp 1 0 0 0 0 0 0",
                     instr_ready_o, done_o, illegal_o, zero_flag_o, alu_a_o, alu_b_o, alu_op_o);
        end
        rst_n_i = 1'b1;
        check_all_regs("reset_regs");
    endtask

    task automatic test_directed();
        run_instr(mk_ldi(1, 5), "ldi_r1");
        run_instr(mk_ldi(2, -3), "ldi_r2");
        run_instr(mk(2, 3, 1, 0, 2 << 2), "add_r3");
        run_instr(mk(3, 4, 3, 1, 2), "sub_r4_imm");
        run_instr(mk(9, 5, 2, 1, 1), "sra_r5");
        run_instr(mk(10, 6, 1, 1, 3), "sl_r6");
        run_instr(mk(8, 7, 2, 1, 4), "sr_r7");
        check_all_regs("directed");
        // Fixed values from hand calculation, independent of the model
        dbg_addr_i = 3'd3; #1; checks++;
        if (dbg_data_o !== 16'h0002) begin errors++; $display("FAIL r3_const got=%h exp=0002", dbg_data_o); end
        dbg_addr_i = 3'd5; #1; checks++;
        if (dbg_data_o !== 16'hFFFE) begin errors++; $display("FAIL r5_const got=%h exp=fffe", dbg_data_o); end
        dbg_addr_i = 3'd6; #1; checks++;
        if (dbg_data_o !== 16'h0028) begin errors++; $display("FAIL r6_const got=%h exp=0028", dbg_data_o); end
        dbg_addr_i = 3'd7; #1; checks++;
        if (dbg_data_o !== 16'h0FFF) begin errors++; $display("FAIL r7_const got=%h exp=0fff", dbg_data_o); end
    endtask

    task automatic test_illegal_r0();
        run_instr(mk(15, 3, 1, 0, 0), "illegal_f");
        run_instr(mk(7, 2, 1, 1, 1), "illegal_7");
        run_instr(mk(2, 0, 1, 0, 1 << 2), "add_r0");
        run_instr(mk(0, 4, 1, 0, 0), "nop");
        check_all_regs("illegal_r0");
    endtask

    task automatic test_reset_mid();
        @(negedge clk_i);
        instr_i = mk(2, 3, 1, 0, 2 << 2); instr_valid_i = 1'b1;
        @(negedge clk_i);
        instr_valid_i = 1'b0;
        rst_n_i = 1'b0;
        model_reset();
        #1;
        checks++;
        if (instr_ready_o !== 1'b1 || done_o !== 1'b0 || alu_op_o !== 4'h0) begin errors++;
            $display("FAIL reset_mid got rdy=%b done=%b op=%h exp rdy=1 done=0 op=0",
                     instr_ready_o, done_o, alu_op_o); end
        check_all_regs("reset_mid_regs");
        @(negedge clk_i);
        rst_n_i = 1'b1;
        repeat (2) begin
            @(negedge clk_i);
            checks++;
            if (done_o !== 1'b0 || zero_flag_o !== 1'b0) begin errors++;
                $display("FAIL reset_mid_nodone got done=%b zf=%b exp 0 0", done_o, zero_flag_o); end
        end
    endtask

    // Valid held high: second acceptance only once the stage returns to IDLE.
    task automatic test_back_to_back();
        run_instr(mk_ldi(1, 3), "b2b_ldi");
        @(negedge clk_i);
        instr_i = mk(2, 1, 1, 0, 1 << 2); instr_valid_i = 1'b1;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(negedge clk_i);
            checks++;
            if (instr_ready_o !== (cyc % 3 == 0) || done_o !== (cyc % 3 == 2)) begin errors++;
                $display("FAIL b2b_cycle%0d got rdy=%b done=%b exp rdy=%b done=%b",
                         cyc, instr_ready_o, done_o, cyc % 3 == 0, cyc % 3 == 2); end
        end
        instr_valid_i = 1'b0;
        @(negedge clk_i);
        mregs[1] = 16'd12; mzf = 1'b0;
        check_all_regs("b2b_regs");
    endtask

    task automatic test_random();
        logic [15:0] ins;
        for (int n = 0; n < 60; n++) begin
            ins = 16'($urandom);
            if ($urandom_range(0, 3) != 0)
                ins[15:12] = 4'($urandom_range(0, 10));
            repeat ($urandom_range(0, 2)) @(negedge clk_i);
            run_instr(ins, $sformatf("rand%0d", n));
        end
        check_all_regs("random");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_illegal_r0();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
